// File: rtl/conseq_run_detector.sv
// rtl/conseq_run_detector.sv - serial run detector for consecutive ones/zeros with event counter
module conseq_run_detector #(
    parameter int ONES_LEN  = 3,
    parameter int ZEROS_LEN = 2,
    parameter int OVERLAP   = 1,
    parameter int CNT_W     = 8,
    localparam int RW = $clog2(((ONES_LEN > ZEROS_LEN) ? ONES_LEN : ZEROS_LEN) + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clear,
    input  logic             x,
    output logic             y_ones,
    output logic             y_zeros,
    output logic             y,
    output logic [RW-1:0]    run_len,
    output logic             det_pulse,
    output logic [CNT_W-1:0] det_count
);

    typedef enum logic [1:0] {IDLE, ONES, ZEROS} state_t;

    localparam logic [RW-1:0] ONES_THR  = RW'(ONES_LEN);
    localparam logic [RW-1:0] ZEROS_THR = RW'(ZEROS_LEN);
    localparam logic [RW-1:0] ONE       = RW'(1);

    state_t           state, state_nxt;
    logic [RW-1:0]    run_cnt, cnt_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [RW-1:0]    thr;
    logic             same;
    logic             det;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            run_cnt   <= '0;
            det_pulse <= 1'b0;
            det_count <= '0;
        end else begin
            state     <= state_nxt;
            run_cnt   <= cnt_nxt;
            det_pulse <= det;
            det_count <= count_nxt;
        end
    end

    // det marks the edge on which run_cnt lands on its threshold
    always_comb begin
        state_nxt = state;
        cnt_nxt   = run_cnt;
        count_nxt = det_count;
        det       = 1'b0;
        thr       = x ? ONES_THR : ZEROS_THR;
        same      = (state == ONES && x) || (state == ZEROS && !x);
        if (clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            count_nxt = '0;
        end else if (en) begin
            if (!same) begin
                state_nxt = x ? ONES : ZEROS;
                cnt_nxt   = ONE;
                det       = (thr == ONE);
            end else if (run_cnt < thr) begin
                cnt_nxt = run_cnt + ONE;
                det     = ((run_cnt + ONE) == thr);
            end else if (OVERLAP == 0) begin
                cnt_nxt = ONE;
                det     = (thr == ONE);
            end
            if (det && det_count != {CNT_W{1'b1}}) begin
                count_nxt = det_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        y_ones  = (state == ONES)  && (run_cnt == ONES_THR);
        y_zeros = (state == ZEROS) && (run_cnt == ZEROS_THR);
        y       = y_ones || y_zeros;
        run_len = run_cnt;
    end

endmodule

// File: tb/tb_conseq_run_detector.sv
// tb/tb_conseq_run_detector.sv - directed self-checking bench for conseq_run_detector
module tb_conseq_run_detector;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en = 1'b0;
    logic clear = 1'b0;
    logic x = 1'b0;

    logic       a_y_ones, a_y_zeros, a_y, a_det_pulse;
    logic [1:0] a_run_len;
    logic [7:0] a_det_count;

    logic       b_y_ones, b_y_zeros, b_y, b_det_pulse;
    logic [1:0] b_run_len;
    logic [7:0] b_det_count;

    logic       c_y_ones, c_y_zeros, c_y, c_det_pulse;
    logic [1:0] c_run_len;
    logic [1:0] c_det_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    conseq_run_detector dut (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .x(x),
        .y_ones(a_y_ones), .y_zeros(a_y_zeros), .y(a_y), .run_len(a_run_len),
        .det_pulse(a_det_pulse), .det_count(a_det_count)
    );

    conseq_run_detector #(.ONES_LEN(3), .OVERLAP(0)) dut_nov (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .x(x),
        .y_ones(b_y_ones), .y_zeros(b_y_zeros), .y(b_y), .run_len(b_run_len),
        .det_pulse(b_det_pulse), .det_count(b_det_count)
    );

    conseq_run_detector #(.ONES_LEN(1), .OVERLAP(0), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .x(x),
        .y_ones(c_y_ones), .y_zeros(c_y_zeros), .y(c_y), .run_len(c_run_len),
        .det_pulse(c_det_pulse), .det_count(c_det_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; en = 1'b1; x = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (a_y !== 1'b0) begin n_err++; $display("FAIL reset_y: got %0b expected 0", a_y); end
        n_cmp++; if (a_run_len !== 2'd0) begin n_err++; $display("FAIL reset_run_len: got %0d expected 0", a_run_len); end
        n_cmp++; if (a_det_pulse !== 1'b0) begin n_err++; $display("FAIL reset_det_pulse: got %0b expected 0", a_det_pulse); end
        n_cmp++; if (a_det_count !== 8'd0) begin n_err++; $display("FAIL reset_det_count: got %0d expected 0", a_det_count); end
        #9 reset_n = 1'b1;
        en = 1'b0; x = 1'b1;
        step();
        n_cmp++; if (a_run_len !== 2'd0) begin n_err++; $display("FAIL idle_hold_run_len: got %0d expected 0", a_run_len); end
    endtask

    task automatic test_ones_run();
        logic       ey [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       ep [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0] er [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        do_clear();
        n_cmp++; if (a_run_len !== 2'd0 || a_y !== 1'b0) begin n_err++; $display("FAIL clear_priority: got run_len=%0d y=%0b expected 0 0", a_run_len, a_y); end
        for (int i = 0; i < 4; i++) begin
            en = 1'b1; x = 1'b1;
            step();
            n_cmp++; if (a_y_ones !== ey[i]) begin n_err++; $display("FAIL ones_y_ones[%0d]: got %0b expected %0b", i, a_y_ones, ey[i]); end
            n_cmp++; if (a_det_pulse !== ep[i]) begin n_err++; $display("FAIL ones_det_pulse[%0d]: got %0b expected %0b", i, a_det_pulse, ep[i]); end
            n_cmp++; if (a_run_len !== er[i]) begin n_err++; $display("FAIL ones_run_len[%0d]: got %0d expected %0d", i, a_run_len, er[i]); end
        end
        n_cmp++; if (a_det_count !== 8'd1) begin n_err++; $display("FAIL ones_det_count: got %0d expected 1", a_det_count); end
    endtask

    task automatic test_zeros_run();
        logic       xs [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       ey [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       ep [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0] er [6] = '{2'd1, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2};
        do_clear();
        for (int i = 0; i < 6; i++) begin
            en = 1'b1; x = xs[i];
            step();
            n_cmp++; if (a_y_zeros !== ey[i] || a_y !== ey[i]) begin n_err++; $display("FAIL zeros_y[%0d]: got y_zeros=%0b y=%0b expected %0b", i, a_y_zeros, a_y, ey[i]); end
            n_cmp++; if (a_det_pulse !== ep[i]) begin n_err++; $display("FAIL zeros_det_pulse[%0d]: got %0b expected %0b", i, a_det_pulse, ep[i]); end
            n_cmp++; if (a_run_len !== er[i]) begin n_err++; $display("FAIL zeros_run_len[%0d]: got %0d expected %0d", i, a_run_len, er[i]); end
        end
        n_cmp++; if (a_det_count !== 8'd2) begin n_err++; $display("FAIL zeros_det_count: got %0d expected 2", a_det_count); end
    endtask

    task automatic test_no_overlap();
        logic       ey [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0] er [6] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
        do_clear();
        for (int i = 0; i < 6; i++) begin
            en = 1'b1; x = 1'b1;
            step();
            n_cmp++; if (b_y_ones !== ey[i]) begin n_err++; $display("FAIL nov_y_ones[%0d]: got %0b expected %0b", i, b_y_ones, ey[i]); end
            n_cmp++; if (b_det_pulse !== ey[i]) begin n_err++; $display("FAIL nov_det_pulse[%0d]: got %0b expected %0b", i, b_det_pulse, ey[i]); end
            n_cmp++; if (b_run_len !== er[i]) begin n_err++; $display("FAIL nov_run_len[%0d]: got %0d expected %0d", i, b_run_len, er[i]); end
        end
        n_cmp++; if (b_det_count !== 8'd2) begin n_err++; $display("FAIL nov_det_count: got %0d expected 2", b_det_count); end
    endtask

    task automatic test_enable_gap();
        do_clear();
        for (int i = 0; i < 2; i++) begin
            en = 1'b1; x = 1'b1;
            step();
        end
        for (int i = 0; i < 5; i++) begin
            en = 1'b0; x = 1'b1;
            step();
            n_cmp++; if (a_y_ones !== 1'b0 || a_det_pulse !== 1'b0) begin n_err++; $display("FAIL gap_flags[%0d]: got y_ones=%0b det_pulse=%0b expected 0 0", i, a_y_ones, a_det_pulse); end
            n_cmp++; if (a_run_len !== 2'd2) begin n_err++; $display("FAIL gap_run_len[%0d]: got %0d expected 2", i, a_run_len); end
        end
        en = 1'b1; x = 1'b1;
        step();
        n_cmp++; if (a_y_ones !== 1'b1) begin n_err++; $display("FAIL gap_y_ones_after: got %0b expected 1", a_y_ones); end
        n_cmp++; if (a_det_pulse !== 1'b1) begin n_err++; $display("FAIL gap_det_pulse_after: got %0b expected 1", a_det_pulse); end
        n_cmp++; if (a_det_count !== 8'd1) begin n_err++; $display("FAIL gap_det_count: got %0d expected 1", a_det_count); end
    endtask

    task automatic test_async_reset();
        logic xs [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            en = 1'b1; x = xs[i];
            step();
        end
        n_cmp++; if (a_run_len !== 2'd2 || a_det_count !== 8'd1) begin n_err++; $display("FAIL pre_reset: got run_len=%0d det_count=%0d expected 2 1", a_run_len, a_det_count); end
        #1 reset_n = 1'b0;
        #1;
        n_cmp++; if (a_run_len !== 2'd0 || a_y !== 1'b0 || a_y_ones !== 1'b0 || a_y_zeros !== 1'b0) begin n_err++; $display("FAIL async_reset_run: got run_len=%0d y=%0b expected 0 0", a_run_len, a_y); end
        n_cmp++; if (a_det_count !== 8'd0 || a_det_pulse !== 1'b0) begin n_err++; $display("FAIL async_reset_det: got det_count=%0d det_pulse=%0b expected 0 0", a_det_count, a_det_pulse); end
        #1 reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            en = 1'b1; x = 1'b1;
            step();
        end
        n_cmp++; if (a_run_len !== 2'd2 || a_y !== 1'b0) begin n_err++; $display("FAIL post_reset_run: got run_len=%0d y=%0b expected 2 0", a_run_len, a_y); end
    endtask

    task automatic test_saturate_clear();
        do_clear();
        for (int i = 0; i < 10; i++) begin
            en = 1'b1; x = 1'b1;
            step();
            n_cmp++; if (c_det_count !== ((i < 3) ? 2'(i + 1) : 2'd3)) begin n_err++; $display("FAIL sat_det_count[%0d]: got %0d expected %0d", i, c_det_count, (i < 3) ? i + 1 : 3); end
            n_cmp++; if (c_y_ones !== 1'b1 || c_det_pulse !== 1'b1) begin n_err++; $display("FAIL sat_flags[%0d]: got y_ones=%0b det_pulse=%0b expected 1 1", i, c_y_ones, c_det_pulse); end
        end
        clear = 1'b1; en = 1'b1; x = 1'b1;
        step();
        clear = 1'b0; en = 1'b0;
        n_cmp++; if (c_det_count !== 2'd0) begin n_err++; $display("FAIL sat_clear_det_count: got %0d expected 0", c_det_count); end
        n_cmp++; if (c_run_len !== 2'd0 || c_y !== 1'b0 || c_det_pulse !== 1'b0) begin n_err++; $display("FAIL sat_clear_state: got run_len=%0d y=%0b det_pulse=%0b expected 0 0 0", c_run_len, c_y, c_det_pulse); end
    endtask

    initial begin
        test_reset();
        test_ones_run();
        test_zeros_run();
        test_no_overlap();
        test_enable_gap();
        test_async_reset();
        test_saturate_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conseq_run_detector.md
CONSEQ_RUN_DETECTOR -- requirements
Module: conseq_run_detector

Interface
REQ-001 Parameter ONES_LEN, default 3: run length of consecutive 1s that asserts y_ones; legal range 1..255.
REQ-002 Parameter ZEROS_LEN, default 2: run length of consecutive 0s that asserts y_zeros; legal range 1..255.
REQ-003 Parameter OVERLAP, default 1: 1 = flag held while the run continues; 0 = run counter restarts after each detection.
REQ-004 Parameter CNT_W, default 8: width of det_count.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  sample enable; x is sampled only at rising edges where en=1.
REQ-008 clear  input  1  synchronous clear of detector state and det_count.
REQ-009 x  input  1  serial data bit.
REQ-010 y_ones  output  1  registered flag: current ones-run has reached ONES_LEN.
REQ-011 y_zeros  output  1  registered flag: current zeros-run has reached ZEROS_LEN.
REQ-012 y  output  1  y_ones OR y_zeros.
REQ-013 run_len  output  RW  current run count; RW = clog2(max(ONES_LEN,ZEROS_LEN)+1).
REQ-014 det_pulse  output  1  one-cycle pulse per detection event.
REQ-015 det_count  output  CNT_W  number of detection events, saturating.

Function
REQ-016 FSM has three states: IDLE (no bit since reset/clear), ONES, ZEROS; run counter run_cnt is RW bits.
REQ-017 Enabled sample from IDLE: x=1 -> ONES with run_cnt=1; x=0 -> ZEROS with run_cnt=1.
REQ-018 Enabled sample of opposite polarity in ONES/ZEROS -> switch to the other state with run_cnt=1.
REQ-019 Enabled sample of same polarity, run_cnt < threshold -> run_cnt increments by 1.
REQ-020 Same polarity, run_cnt = threshold, OVERLAP=1 -> run_cnt holds at threshold (saturates).
REQ-021 Same polarity, run_cnt = threshold, OVERLAP=0 -> run_cnt becomes 1; threshold 1 therefore re-detects every sample.
REQ-022 y_ones = (state==ONES && run_cnt==ONES_LEN); y_zeros = (state==ZEROS && run_cnt==ZEROS_LEN); Moore outputs, no combinational path from x.
REQ-023 Latency: flag asserts in the cycle following the rising edge that samples the Nth bit of the run.
REQ-024 run_len equals run_cnt; run_len is 0 in IDLE.
REQ-025 Detection event: the edge where run_cnt transitions into threshold (from threshold-1, or from the reset value 1 when OVERLAP=0, or on run start when threshold=1).
REQ-026 det_pulse is registered, high for exactly one cycle, aligned with the first cycle of the flag for that event.
REQ-027 det_count increments by 1 per detection event and holds at 2^CNT_W-1 (no wrap).
REQ-028 en=0: state, run_cnt, flags and det_count hold; det_pulse is 0.
REQ-029 clear=1 takes priority over en: next state IDLE, run_cnt=0, det_count=0, det_pulse=0, x ignored that cycle.
REQ-030 With OVERLAP=1 and defaults, behaviour equals: y after 3 consecutive 1s or 2 consecutive 0s, held while the run continues.

Reset
REQ-031 reset_n=0 immediately (asynchronously) forces IDLE, run_cnt=0, y=y_ones=y_zeros=0, run_len=0, det_pulse=0, det_count=0.
REQ-032 Reset asserted mid-run discards the partial run; the first enabled sample after release starts a new run at 1.
REQ-033 Reset release is synchronised only by the first rising edge; no sample is taken in the edge coincident with release.

Verification
REQ-034 Defaults, en=1, x=1,1,1,1 -> y_ones rises after 3rd edge, stays high; det_pulse once; det_count=1; run_len=3.
REQ-035 Defaults, x=0,0,1,0,0,0 -> y_zeros high after 2nd edge, low after the 1, high again after 5th edge; det_count=2.
REQ-036 OVERLAP=0, ONES_LEN=3, six 1s -> y_ones high for one cycle after 3rd and after 6th edges; det_count=2.
REQ-037 Defaults, x=1,1 then en=0 for 5 cycles with x=1 then en=1, x=1 -> y_ones asserts only after the enabled 3rd 1.
REQ-038 CNT_W=2, OVERLAP=0, ONES_LEN=1, ten 1s -> det_count saturates at 3; clear -> det_count=0, run_len=0, y=0.
REQ-039 Mid-run (run_len=2 ones), pulse reset_n low between edges -> all outputs 0 at once; after release, two 1s give run_len=2, y=0.
